// File: rtl/audiomap_sequencer.sv
// Ping-pong playback scheduler: alternates sector decodes between two audio RAM buffers.
// Latency: arm -> WAIT_BUF in 2 cycles; decoder idle edge -> next start in HOLDOFF+2 cycles.
// Backpressure: a start waits until the wanted buffer is host-filled and the decoder is idle.
//
// Ports:
//   clk, reset (async active-low, deasserted synchronously inside)
//   enable            level; registered rising edge arms the map, falling edge acts as stop
//   stop_req          pulse; stop playback after the current sample
//   cdda_in           level; CDDA mode captured for each start
//   buf_ready_set[1:0] pulses; host marks buffer n filled
//   irq_ack           pulse; clears irq (a same-cycle set wins)
//   decoder_idle      decoder idle status
//   disable_audiomap  decoder pulse on 0xFF coding; ends the map
//   start_playback / playback_addr / reset_filter_on_start / stop_playback / cdda_mode -> decoder
//   active, cur_buf, buf_ready, irq, underrun, map_ended -> register file
module audiomap_sequencer #(
    parameter logic [12:0] BUF0_ADDR = 13'h0A00,
    parameter logic [12:0] BUF1_ADDR = 13'h0F00,
    parameter int unsigned HOLDOFF   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        stop_req,
    input  logic        cdda_in,
    input  logic [1:0]  buf_ready_set,
    input  logic        irq_ack,
    input  logic        decoder_idle,
    input  logic        disable_audiomap,
    output logic        start_playback,
    output logic [12:0] playback_addr,
    output logic        reset_filter_on_start,
    output logic        stop_playback,
    output logic        cdda_mode,
    output logic        active,
    output logic        cur_buf,
    output logic [1:0]  buf_ready,
    output logic        irq,
    output logic        underrun,
    output logic        map_ended
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_WAIT_BUF  = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_HOLDOFF   = 3'd5,
        S_STOPPING  = 3'd6
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

    // ------------------------------------------------------------------
    // Reset synchronizer: asserts immediately, releases on a clock edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Enable edge detection (registered) and event decode
    // ------------------------------------------------------------------
    logic en_q, en_prev_q;
    logic arm, en_fall, stop_evt, dis_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            en_q      <= enable;
            en_prev_q <= en_q;
        end
    end

    state_t state_q, state_d;

    assign arm      = en_q & ~en_prev_q;
    assign en_fall  = ~en_q & en_prev_q;
    assign stop_evt = stop_req | en_fall;
    assign dis_evt  = disable_audiomap & (state_q != S_OFF);

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic        cur_buf_q, cur_buf_d;
    logic        first_q, first_d;
    logic [1:0]  buf_ready_q, buf_ready_d;
    logic        irq_q, irq_d;
    logic        underrun_q, underrun_d;
    logic        map_ended_q, map_ended_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [12:0] addr_q, addr_d;
    logic        cdda_q, cdda_d;
    logic        stop_pb_q, stop_pb_d;
    logic        consume;
    logic        enter_start;
    logic [1:0]  clr_vec;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Priority is disable > stop > normal progress.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF: begin
                if (arm) state_d = S_WAIT_BUF;
            end
            S_WAIT_BUF: begin
                if (stop_evt) begin
                    state_d = S_OFF;
                end else if (buf_ready_q[cur_buf_q] && decoder_idle) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // The start pulse has already gone out, so a stop here must
                // wait for the decoder to quiesce rather than drop to OFF.
                state_d = stop_evt ? S_STOPPING : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Decoder still reports idle on this cycle; do not sample it.
                state_d = stop_evt ? S_STOPPING : S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (stop_evt) begin
                    state_d = S_STOPPING;
                end else if (decoder_idle) begin
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (stop_evt) begin
                    state_d = S_OFF;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_WAIT_BUF;
                end
            end
            S_STOPPING: begin
                if (decoder_idle) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
        if (dis_evt) state_d = S_OFF;
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    assign consume     = (state_q == S_WAIT_DONE) && (state_d == S_HOLDOFF);
    assign enter_start = (state_d == S_START);
    assign clr_vec     = consume ? (cur_buf_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        cur_buf_d   = cur_buf_q;
        first_d     = first_q;
        underrun_d  = underrun_q;
        map_ended_d = map_ended_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        cdda_d      = cdda_q;

        if ((state_q == S_OFF) && arm) begin
            cur_buf_d   = 1'b0;
            first_d     = 1'b1;
            underrun_d  = 1'b0;
            map_ended_d = 1'b0;
        end

        if ((state_q == S_WAIT_BUF) && (state_d == S_WAIT_BUF) && !buf_ready_q[cur_buf_q]) begin
            underrun_d = 1'b1;
        end

        // Address and mode are captured on entry so they are valid
        // alongside the start pulse and held afterwards.
        if (enter_start) begin
            addr_d = cur_buf_q ? BUF1_ADDR : BUF0_ADDR;
            cdda_d = cdda_in;
        end

        if (state_q == S_START) first_d = 1'b0;

        if (consume) begin
            cur_buf_d = ~cur_buf_q;
            cnt_d     = HOLD_LOAD;
        end else if ((state_q == S_HOLDOFF) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (dis_evt) map_ended_d = 1'b1;
    end

    // Set has priority over clear for both the buffer flags and irq.
    assign buf_ready_d = buf_ready_set | (buf_ready_q & ~clr_vec);
    assign irq_d       = consume | dis_evt | (irq_q & ~irq_ack);
    assign stop_pb_d   = (state_d == S_STOPPING) && (state_q != S_STOPPING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_buf_q   <= 1'b0;
            first_q     <= 1'b0;
            buf_ready_q <= 2'b00;
            irq_q       <= 1'b0;
            underrun_q  <= 1'b0;
            map_ended_q <= 1'b0;
            cnt_q       <= 4'd0;
            addr_q      <= BUF0_ADDR;
            cdda_q      <= 1'b0;
            stop_pb_q   <= 1'b0;
        end else begin
            cur_buf_q   <= cur_buf_d;
            first_q     <= first_d;
            buf_ready_q <= buf_ready_d;
            irq_q       <= irq_d;
            underrun_q  <= underrun_d;
            map_ended_q <= map_ended_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            cdda_q      <= cdda_d;
            stop_pb_q   <= stop_pb_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        start_playback        = (state_q == S_START);
        reset_filter_on_start = (state_q == S_START) & first_q;
        active                = (state_q != S_OFF);
        stop_playback         = stop_pb_q;
        playback_addr         = addr_q;
        cdda_mode             = cdda_q;
        cur_buf               = cur_buf_q;
        buf_ready             = buf_ready_q;
        irq                   = irq_q;
        underrun              = underrun_q;
        map_ended             = map_ended_q;
    end

endmodule

// File: doc/audiomap_sequencer.md
# audiomap_sequencer

Ping-pong playback scheduler for the audio decoder. It owns the decoder's `start_playback`/`playback_addr`/`stop_playback` controls and alternates between two fixed sector buffers in audio RAM, starting one sector decode per host-filled buffer. After each sector it raises an interrupt toward the CDIC register file, and it shuts down on host stop or on an end-of-map (0xFF coding) indication from the decoder.

## Interface
Parameters:
- `BUF0_ADDR`, 13'h0A00: word address of buffer 0 (byte 0x1400).
- `BUF1_ADDR`, 13'h0F00: word address of buffer 1 (byte 0x1E00).
- `HOLDOFF`, 4: idle cycles inserted between the end of one sector and the next start. Legal range 1..15.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: level; rising edge (0→1, registered) arms the map.
- `stop_req`, in, 1: pulse; stop playback after the current sample.
- `cdda_in`, in, 1: level; CDDA mode for subsequent starts.
- `buf_ready_set`, in, 2: pulses; host marks buffer *n* filled.
- `irq_ack`, in, 1: pulse; clears `irq`.
- `decoder_idle`, in, 1: decoder `idle`.
- `disable_audiomap`, in, 1: decoder pulse on 0xFF coding.
- `start_playback`, out, 1: one-cycle start pulse to the decoder.
- `playback_addr`, out, 13: buffer address; valid while `start_playback` is high and held afterwards.
- `reset_filter_on_start`, out, 1: high with the first start after arming only.
- `stop_playback`, out, 1: one-cycle stop pulse to the decoder.
- `cdda_mode`, out, 1: `cdda_in` latched at each start.
- `active`, out, 1: high in every state except OFF.
- `cur_buf`, out, 1: buffer index to be played next or now playing.
- `buf_ready`, out, 2: per-buffer filled flags.
- `irq`, out, 1: sticky sector-done / map-end interrupt.
- `underrun`, out, 1: sticky; a buffer was wanted but not ready. Cleared on arm.
- `map_ended`, out, 1: sticky; the map was ended by `disable_audiomap`. Cleared on arm.

## Operation
- States: OFF, WAIT_BUF, START, WAIT_BUSY, WAIT_DONE, HOLDOFF, STOPPING.
- OFF:
  - On the registered `enable` rising edge: `cur_buf`←0, `first`←1, `underrun`←0, `map_ended`←0, go to WAIT_BUF.
  - Pulses on `stop_req` and `disable_audiomap` are ignored.
- WAIT_BUF:
  - If `buf_ready[cur_buf]` and `decoder_idle`, go to START.
  - Otherwise set `underrun` (only when the buffer is not ready) and stay.
- START (one cycle):
  - `start_playback`=1, `playback_addr`=BUFn_ADDR, `reset_filter_on_start`=`first`, `cdda_mode`←`cdda_in`.
  - `first`←0, go to WAIT_BUSY.
- WAIT_BUSY: wait one cycle for the decoder to leave IDLE, then go to WAIT_DONE. `decoder_idle` is not sampled in this state.
- WAIT_DONE, on `decoder_idle`=1:
  - Clear `buf_ready[cur_buf]` and set `irq`.
  - Toggle `cur_buf`, load the holdoff counter with HOLDOFF−1, go to HOLDOFF.
- HOLDOFF: decrement the counter; go to WAIT_BUF at 0.
- `disable_audiomap` in any non-OFF state:
  - Set `map_ended` and `irq`, then go to OFF.
  - Buffer flags are untouched; `cur_buf` holds.
- `stop_req` in WAIT_DONE or WAIT_BUSY: pulse `stop_playback` one cycle, go to STOPPING.
- STOPPING: on `decoder_idle` go to OFF. No `irq`; the buffer is not consumed.
- `stop_req` in WAIT_BUF, HOLDOFF or START: go to OFF. If in START, the start pulse is still issued that cycle, and the state goes to STOPPING instead of OFF.
- `enable` falling while not OFF is treated as `stop_req`.
- Event priority in one cycle: `disable_audiomap` > `stop_req` > normal transition.
- `buf_ready` update:
  - Bit *n* is set by `buf_ready_set[n]` and cleared by consumption.
  - Set and clear on the same bit in the same cycle: set wins.
  - Setting an already-set bit has no effect.
- `irq`: set wins over `irq_ack` in the same cycle.

## Timing
- Reset (async assert, sync deassert internally):
  - State OFF.
  - All outputs 0, except `playback_addr`=BUF0_ADDR.
  - Counters 0, `first`=0.
- Arm latency: `enable` rising edge → WAIT_BUF 2 cycles later (1 cycle edge register, 1 cycle transition). `start_playback` follows on the next cycle if the buffer is ready and the decoder idle.
- Turnaround: `decoder_idle` rising in WAIT_DONE → `irq` high next cycle → next `start_playback` exactly HOLDOFF+2 cycles after the idle edge, if the next buffer is ready.
- `buf_ready_set` is visible to WAIT_BUF one cycle after assertion.
- `start_playback` and `stop_playback` are never high for more than one consecutive cycle and are never high together.

## Test plan
- **Basic ping-pong.** Arm with `buf_ready_set`=2'b11, HOLDOFF=4, decoder model busy for 100 cycles. Required:
  - Starts at addresses 0x0A00 then 0x0F00.
  - `reset_filter_on_start` is 1 only on the first start.
  - Starts are 106 cycles apart.
  - `buf_ready` reaches 2'b00 and `irq` rises twice.
- **Underrun.** Arm with only buffer 0 ready. Required:
  - After sector 0, `underrun`=1 and no start is issued.
  - `buf_ready_set`=2'b10 → start at 0x0F00 two cycles later.
- **Stop mid-sector.** `stop_req` 20 cycles into a decode. Required:
  - `stop_playback` pulses once the next cycle.
  - After `decoder_idle`, `active`=0, `buf_ready[0]` is still 1, and `irq`=0.
- **Map end.** `disable_audiomap` pulse during WAIT_DONE. Required: OFF next cycle, `map_ended`=1, `irq`=1.
- **Simultaneous events.** `buf_ready_set[0]` on the same cycle buffer 0 is consumed → `buf_ready[0]` stays 1. `irq_ack` on the same cycle as a new `irq` set → `irq` stays 1.
- **Reset mid-operation.** Assert `reset` low during WAIT_DONE. Required:
  - All outputs immediately 0 and `playback_addr`=0x0A00.
  - After release, no start until a new arm.
